pw_trigger_sequencer: RTL and testbench



---
 rtl/pw_trigger_sequencer_pkg.sv | 15 +
 rtl/pw_trigger_sequencer_table.sv | 37 +++
 rtl/pw_trigger_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_pw_trigger_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pw_trigger_sequencer_pkg.sv
// Shared types and helpers for the pulse-burst trigger sequencer.
package pw_trigger_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StDelay = 2'd2,
        StPulse = 2'd3
    } seq_state_e;

    function automatic int unsigned max_width(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pw_trigger_sequencer_table.sv
// Per-entry (delay, width) register file for the trigger sequencer.
// Synchronous write, combinational read by index.
module pw_trigger_sequencer_table #(
    parameter int unsigned pTRIGGER_DELAY_WIDTH = 20,
    parameter int unsigned pTRIGGER_WIDTH_WIDTH = 17,
    parameter int unsigned pNUM_ENTRIES         = 8
) (
    input  logic                              trigger_clk,
    input  logic                              reset_n,
    input  logic                              we_i,
    input  logic [$clog2(pNUM_ENTRIES)-1:0]   wr_addr_i,
    input  logic [pTRIGGER_DELAY_WIDTH-1:0]   wr_delay_i,
    input  logic [pTRIGGER_WIDTH_WIDTH-1:0]   wr_width_i,
    input  logic [$clog2(pNUM_ENTRIES)-1:0]   rd_index_i,
    output logic [pTRIGGER_DELAY_WIDTH-1:0]   rd_delay_o,
    output logic [pTRIGGER_WIDTH_WIDTH-1:0]   rd_width_o
);

    logic [pTRIGGER_DELAY_WIDTH-1:0] delay_q [pNUM_ENTRIES];
    logic [pTRIGGER_WIDTH_WIDTH-1:0] width_q [pNUM_ENTRIES];

    always_ff @(posedge trigger_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(pNUM_ENTRIES); i++) begin
                delay_q[i] <= '0;
                width_q[i] <= '0;
            end
        end else if (we_i) begin
            delay_q[wr_addr_i] <= wr_delay_i;
            width_q[wr_addr_i] <= wr_width_i;
        end
    end

    assign rd_delay_o = delay_q[rd_index_i];
    assign rd_width_o = width_q[rd_index_i];

endmodule

// File: rtl/pw_trigger_sequencer.sv
// Pulse-burst trigger sequencer: walks a (delay, width) table after each armed match.
// Define PW_TRIG_SEQ_MISSED_CNT_EN to add O_missed_count for matches dropped while busy.
module pw_trigger_sequencer
    import pw_trigger_sequencer_pkg::*;
#(
    parameter int unsigned pTRIGGER_DELAY_WIDTH = 20,
    parameter int unsigned pTRIGGER_WIDTH_WIDTH = 17,
    parameter int unsigned pNUM_ENTRIES         = 8,
    parameter int unsigned pCOUNT_WIDTH         = 16
) (
    input  logic                              trigger_clk,
    input  logic                              reset_n,
    input  logic                              I_arm,
    input  logic                              I_disarm,
    input  logic                              I_rearm_en,
    input  logic [$clog2(pNUM_ENTRIES):0]     I_num_entries,
    input  logic                              I_tbl_we,
    input  logic [$clog2(pNUM_ENTRIES)-1:0]   I_tbl_addr,
    input  logic [pTRIGGER_DELAY_WIDTH-1:0]   I_tbl_delay,
    input  logic [pTRIGGER_WIDTH_WIDTH-1:0]   I_tbl_width,
    input  logic                              I_match,
    output logic                              O_trigger,
    output logic                              O_trigger_pulse,
    output logic                              O_armed,
    output logic                              O_busy,
    output logic                              O_done,
    output logic [$clog2(pNUM_ENTRIES)-1:0]   O_seq_index,
    output logic [pCOUNT_WIDTH-1:0]           O_trigger_count,
`ifdef PW_TRIG_SEQ_MISSED_CNT_EN
    output logic [pCOUNT_WIDTH-1:0]           O_missed_count,
`endif
    output logic                              O_tbl_wr_err
);

    localparam int unsigned IdxW = $clog2(pNUM_ENTRIES);
    localparam int unsigned NumW = IdxW + 1;
    localparam int unsigned CntW = max_width(pTRIGGER_DELAY_WIDTH, pTRIGGER_WIDTH_WIDTH);

    seq_state_e                      state_q;
    logic [CntW-1:0]                 cnt_q;
    logic [pTRIGGER_DELAY_WIDTH-1:0] del_q, tbl_delay;
    logic [pTRIGGER_WIDTH_WIDTH-1:0] wid_q, tbl_width, wid_eff;
    logic [IdxW-1:0]                 idx_q, tbl_rd_idx;
    logic [NumW-1:0]                 num_q, num_eff;
    logic [pCOUNT_WIDTH-1:0]         count_q;
    logic                            rearm_q, trig_q, trig_pulse_q, done_q, wr_err_q;
    logic                            busy, arm_go, last_entry;

    always_comb begin
        busy       = (state_q == StDelay) || (state_q == StPulse);
        arm_go     = I_arm && !I_disarm && !busy;
        last_entry = (({1'b0, idx_q} + NumW'(1)) == num_q);
        wid_eff    = (wid_q == '0) ? pTRIGGER_WIDTH_WIDTH'(1) : wid_q;
        // Entry 0 is fetched on the match; later entries on the previous pulse's fall.
        tbl_rd_idx = (state_q == StArmed) ? '0 : idx_q + IdxW'(1);
        num_eff    = I_num_entries;
        if (I_num_entries == '0) begin
            num_eff = NumW'(1);
        end else if (I_num_entries > NumW'(pNUM_ENTRIES)) begin
            num_eff = NumW'(pNUM_ENTRIES);
        end
    end

    pw_trigger_sequencer_table #(
        .pTRIGGER_DELAY_WIDTH (pTRIGGER_DELAY_WIDTH),
        .pTRIGGER_WIDTH_WIDTH (pTRIGGER_WIDTH_WIDTH),
        .pNUM_ENTRIES         (pNUM_ENTRIES)
    ) u_table (
        .trigger_clk (trigger_clk),
        .reset_n     (reset_n),
        .we_i        (I_tbl_we && !busy),
        .wr_addr_i   (I_tbl_addr),
        .wr_delay_i  (I_tbl_delay),
        .wr_width_i  (I_tbl_width),
        .rd_index_i  (tbl_rd_idx),
        .rd_delay_o  (tbl_delay),
        .rd_width_o  (tbl_width)
    );

    always_ff @(posedge trigger_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            del_q        <= '0;
            wid_q        <= '0;
            idx_q        <= '0;
            num_q        <= '0;
            count_q      <= '0;
            rearm_q      <= 1'b0;
            trig_q       <= 1'b0;
            trig_pulse_q <= 1'b0;
            done_q       <= 1'b0;
            wr_err_q     <= 1'b0;
        end else begin
            trig_pulse_q <= 1'b0;
            done_q       <= 1'b0;
            if (I_tbl_we && busy) begin
                wr_err_q <= 1'b1;
            end
            unique case (state_q)
                StIdle, StArmed: begin
                    if (I_disarm) begin
                        state_q <= StIdle;
                    end else if (arm_go) begin
                        state_q  <= StArmed;
                        rearm_q  <= I_rearm_en;
                        num_q    <= num_eff;
                        count_q  <= '0;
                        idx_q    <= '0;
                        wr_err_q <= 1'b0;
                    end else if ((state_q == StArmed) && I_match) begin
                        state_q <= StDelay;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        del_q   <= tbl_delay;
                        wid_q   <= tbl_width;
                    end
                end
                StDelay: begin
                    if (I_disarm) begin
                        state_q <= StIdle;
                    end else if (cnt_q == CntW'(del_q)) begin
                        state_q      <= StPulse;
                        trig_q       <= 1'b1;
                        trig_pulse_q <= 1'b1;
                        count_q      <= count_q + pCOUNT_WIDTH'(1);
                        cnt_q        <= CntW'(1);
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StPulse: begin
                    if (I_disarm) begin
                        state_q <= StIdle;
                        trig_q  <= 1'b0;
                    end else if (cnt_q >= CntW'(wid_eff)) begin
                        trig_q <= 1'b0;
                        if (last_entry) begin
                            done_q  <= 1'b1;
                            state_q <= rearm_q ? StArmed : StIdle;
                        end else begin
                            state_q <= StDelay;
                            idx_q   <= idx_q + IdxW'(1);
                            cnt_q   <= '0;
                            del_q   <= tbl_delay;
                            wid_q   <= tbl_width;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
            endcase
        end
    end

`ifdef PW_TRIG_SEQ_MISSED_CNT_EN
    logic [pCOUNT_WIDTH-1:0] missed_q;

    always_ff @(posedge trigger_clk or negedge reset_n) begin
        if (!reset_n) begin
            missed_q <= '0;
        end else if (arm_go) begin
            missed_q <= '0;
        end else if (busy && I_match && (missed_q != '1)) begin
            missed_q <= missed_q + pCOUNT_WIDTH'(1);
        end
    end

    assign O_missed_count = missed_q;
`endif

    assign O_trigger       = trig_q;
    assign O_trigger_pulse = trig_pulse_q;
    assign O_armed         = (state_q == StArmed);
    assign O_busy          = busy;
    assign O_done          = done_q;
    assign O_seq_index     = idx_q;
    assign O_trigger_count = count_q;
    assign O_tbl_wr_err    = wr_err_q;

endmodule

// File: tb/tb_pw_trigger_sequencer.sv
// Bench for pw_trigger_sequencer: directed scenarios plus random traffic against a
// schedule-based model (pulse rise/fall edges computed up front for each burst).
module tb_pw_trigger_sequencer;

    localparam int unsigned NE = 8;

    logic        trigger_clk = 1'b0;
    logic        reset_n;
    logic        arm, disarm, rearm_en, tbl_we, match;
    logic [3:0]  num_entries;
    logic [2:0]  tbl_addr;
    logic [19:0] tbl_delay;
    logic [16:0] tbl_width;
    logic        trig, trig_pulse, armed, busy, done, tbl_wr_err;
    logic [2:0]  seq_index;
    logic [15:0] trig_count;
`ifdef PW_TRIG_SEQ_MISSED_CNT_EN
    logic [15:0] missed_count;
`endif

    always #5 trigger_clk = ~trigger_clk;

    pw_trigger_sequencer dut (
        .trigger_clk     (trigger_clk),
        .reset_n         (reset_n),
        .I_arm           (arm),
        .I_disarm        (disarm),
        .I_rearm_en      (rearm_en),
        .I_num_entries   (num_entries),
        .I_tbl_we        (tbl_we),
        .I_tbl_addr      (tbl_addr),
        .I_tbl_delay     (tbl_delay),
        .I_tbl_width     (tbl_width),
        .I_match         (match),
        .O_trigger       (trig),
        .O_trigger_pulse (trig_pulse),
        .O_armed         (armed),
        .O_busy          (busy),
        .O_done          (done),
        .O_seq_index     (seq_index),
        .O_trigger_count (trig_count),
`ifdef PW_TRIG_SEQ_MISSED_CNT_EN
        .O_missed_count  (missed_count),
`endif
        .O_tbl_wr_err    (tbl_wr_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: abstract mode flags plus a precomputed pulse schedule per burst.
    logic        m_armed, m_busy, m_rearm, m_trig, m_tpulse, m_done, m_err;
    int unsigned m_num, m_idx, m_burst_n;
    logic [15:0] m_count, m_missed;
    int unsigned tbl_d [NE];
    int unsigned tbl_w [NE];
    int          rise_t [NE];
    int          fall_t [NE];
    int          edge_n;

    task automatic model_reset();
        m_armed = 0; m_busy = 0; m_rearm = 0; m_trig = 0; m_tpulse = 0; m_done = 0;
        m_err = 0; m_num = 0; m_idx = 0; m_burst_n = 0; m_count = '0; m_missed = '0;
        edge_n = 0;
        for (int i = 0; i < int'(NE); i++) begin
            tbl_d[i] = 0;
            tbl_w[i] = 0;
        end
    endtask

    task automatic start_burst(input int unsigned d0, input int unsigned w0);
        int t;
        int unsigned d, w;
        t = edge_n;
        m_busy = 1; m_armed = 0; m_idx = 0; m_burst_n = m_num;
        for (int k = 0; k < int'(m_burst_n); k++) begin
            d = (k == 0) ? d0 : tbl_d[k];
            w = (k == 0) ? w0 : tbl_w[k];
            if (w == 0) w = 1;
            rise_t[k] = t + 1 + int'(d);
            fall_t[k] = rise_t[k] + int'(w);
            t = fall_t[k];
        end
    endtask

    task automatic model_step();
        int unsigned d0, w0;
        logic was_busy, was_armed;
        if (!reset_n) begin
            model_reset();
        end else begin
            edge_n++;
            was_busy = m_busy;
            was_armed = m_armed;
            m_tpulse = 0;
            m_done = 0;
            if (tbl_we && was_busy) m_err = 1;
            if (match && was_busy && m_missed != 16'hffff) m_missed++;
            if (!was_busy) begin
                d0 = tbl_d[0];
                w0 = tbl_w[0];
                if (tbl_we) begin
                    tbl_d[tbl_addr] = int'(tbl_delay);
                    tbl_w[tbl_addr] = int'(tbl_width);
                end
                if (disarm) begin
                    m_armed = 0;
                end else if (arm) begin
                    m_armed = 1; m_rearm = rearm_en; m_count = '0; m_err = 0;
                    m_idx = 0; m_missed = '0;
                    m_num = int'(num_entries);
                    if (m_num == 0) m_num = 1;
                    else if (m_num > NE) m_num = NE;
                end else if (was_armed && match) begin
                    start_burst(d0, w0);
                end
            end else if (disarm) begin
                m_busy = 0;
                m_trig = 0;
            end else begin
                for (int k = 0; k < int'(m_burst_n); k++) begin
                    if (edge_n == rise_t[k]) begin
                        m_trig = 1; m_tpulse = 1; m_count++;
                    end
                    if (edge_n == fall_t[k]) begin
                        m_trig = 0;
                        if (k == int'(m_burst_n) - 1) begin
                            m_done = 1; m_busy = 0; m_armed = m_rearm;
                        end else begin
                            m_idx = k + 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        check_eq("trigger", 32'(trig), 32'(m_trig));
        check_eq("trigger_pulse", 32'(trig_pulse), 32'(m_tpulse));
        check_eq("armed", 32'(armed), 32'(m_armed));
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("done", 32'(done), 32'(m_done));
        check_eq("seq_index", 32'(seq_index), m_idx);
        check_eq("trigger_count", 32'(trig_count), 32'(m_count));
        check_eq("tbl_wr_err", 32'(tbl_wr_err), 32'(m_err));
`ifdef PW_TRIG_SEQ_MISSED_CNT_EN
        check_eq("missed_count", 32'(missed_count), 32'(m_missed));
`endif
    endtask

    task automatic tick();
        @(posedge trigger_clk);
        model_step();
        #1;
        compare_all();
        @(negedge trigger_clk);
        arm = 0; disarm = 0; match = 0; tbl_we = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write_entry(input int a, input int d, input int w);
        tbl_we = 1; tbl_addr = 3'(a); tbl_delay = 20'(d); tbl_width = 17'(w);
        tick();
    endtask

    task automatic do_arm(input int n, input logic r);
        arm = 1; num_entries = 4'(n); rearm_en = r;
        tick();
    endtask

    task automatic do_match();
        match = 1;
        tick();
    endtask

    logic [16:0] wave;
    logic [16:0] wave_exp;

    initial begin
        reset_n = 0; arm = 0; disarm = 0; rearm_en = 0; tbl_we = 0; match = 0;
        num_entries = '0; tbl_addr = '0; tbl_delay = '0; tbl_width = '0;
        wave = '0;
        wave_exp = 17'b00111010000001100;
        model_reset();
        @(negedge trigger_clk);
        idle(3);
        check_eq("rst_trigger", 32'(trig), 32'd0);
        check_eq("rst_count", 32'(trig_count), 32'd0);
        reset_n = 1;

        // Single entry D=0 W=1
        write_entry(0, 0, 1);
        do_arm(1, 0);
        idle(6);
        do_match();
        tick();
        check_eq("tp1_high", 32'(trig), 32'd1);
        tick();
        check_eq("tp1_low", 32'(trig), 32'd0);
        check_eq("tp1_done", 32'(done), 32'd1);
        check_eq("tp1_idle", 32'(armed | busy), 32'd0);
        check_eq("tp1_count", 32'(trig_count), 32'd1);

        // Three entries: waveform high3 low1 high1 low6 high2
        write_entry(0, 2, 3);
        write_entry(1, 0, 0);
        write_entry(2, 5, 2);
        do_arm(3, 0);
        do_match();
        for (int i = 0; i < 17; i++) begin
            tick();
            wave = {wave[15:0], trig};
        end
        check_eq("tp2_wave", 32'(wave), 32'(wave_exp));
        check_eq("tp2_count", 32'(trig_count), 32'd3);
        check_eq("tp2_index", 32'(seq_index), 32'd2);

        // Auto re-arm, two entries, two matches
        do_arm(2, 1);
        do_match();
        idle(49);
        check_eq("tp3_armed_between", 32'(armed), 32'd1);
        do_match();
        idle(30);
        check_eq("tp3_count", 32'(trig_count), 32'd4);
        check_eq("tp3_armed", 32'(armed), 32'd1);
        disarm = 1;
        tick();

        // Disarm during the second cycle of a W=10 pulse
        write_entry(0, 1, 10);
        do_arm(1, 0);
        do_match();
        idle(3);
        disarm = 1;
        tick();
        check_eq("tp4_trig_low", 32'(trig), 32'd0);
        check_eq("tp4_idle", 32'(armed | busy), 32'd0);
        idle(12);

        // Table write while busy is dropped; extra matches during a long delay
        write_entry(0, 20, 1);
        do_arm(1, 0);
        do_match();
        write_entry(0, 3, 1);
        check_eq("tp5_wr_err", 32'(tbl_wr_err), 32'd1);
        do_match();
        tick();
        do_match();
        tick();
        do_match();
`ifdef PW_TRIG_SEQ_MISSED_CNT_EN
        check_eq("tp6_missed", 32'(missed_count), 32'd3);
`endif
        idle(30);
        do_arm(1, 0);
        check_eq("tp5_err_clear", 32'(tbl_wr_err), 32'd0);

        // Entry-count clamping
        for (int i = 0; i < int'(NE); i++) write_entry(i, 0, 1);
        do_arm(0, 0);
        do_match();
        idle(5);
        check_eq("tp7_num0", 32'(trig_count), 32'd1);
        do_arm(15, 0);
        do_match();
        idle(25);
        check_eq("tp7_num15", 32'(trig_count), 32'd8);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            arm       = ($urandom_range(0, 29) == 0);
            disarm    = ($urandom_range(0, 79) == 0);
            match     = ($urandom_range(0, 5) == 0);
            tbl_we    = ($urandom_range(0, 9) == 0);
            tbl_addr  = 3'($urandom_range(0, 7));
            tbl_delay = 20'($urandom_range(0, 6));
            tbl_width = 17'($urandom_range(0, 4));
            if (arm) begin
                num_entries = 4'($urandom_range(0, 15));
                rearm_en    = 1'($urandom_range(0, 1));
            end
            tick();
        end

        // Asynchronous reset in the middle of a pulse
        disarm = 1;
        tick();
        write_entry(0, 0, 8);
        do_arm(1, 0);
        do_match();
        idle(3);
        reset_n = 0;
        #1;
        model_reset();
        check_eq("async_rst_trig", 32'(trig), 32'd0);
        compare_all();
        idle(2);
        reset_n = 1;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
